// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads the combinational ROM and buffers
// fetched {pc, instr} pairs in a small circular prefetch FIFO drained by decode.
module instr_fetch_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RESET_PC      = 0,
  parameter int unsigned FIFO_DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [ADDRESS_WIDTH-1:0]      imem_addr,
  input  logic [DATA_WIDTH-1:0]         imem_instr,
  input  logic                          halt,
  input  logic                          redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_instr,
  output logic [ADDRESS_WIDTH-1:0]      out_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDRESS_WIDTH-1:0] ResetPc = ADDRESS_WIDTH'(RESET_PC);

  logic [ADDRESS_WIDTH-1:0] fpc_q, fpc_d;
  logic [ADDRESS_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_mem_d    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]          head_q, head_d;
  logic [PtrW-1:0]          tail_q, tail_d;
  logic [CntW-1:0]          count_q, count_d;
  logic                     pop, push;

  // Fetch granularity is a word; the byte offset of a redirect target is dropped.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    pop         = (count_q != '0) && out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO keeps streaming without a bubble.
    push        = !redirect_valid && !halt && ((count_q < CntW'(FIFO_DEPTH)) || pop);
    fpc_d       = fpc_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    if (redirect_valid) begin
      fpc_d   = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]    = fpc_q;
        instr_mem_d[tail_q] = imem_instr;
        tail_d              = tail_q + PtrW'(1);
        fpc_d               = fpc_q + ADDRESS_WIDTH'(4);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q   <= ResetPc;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fpc_q       <= fpc_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  assign imem_addr  = fpc_q;
  assign out_valid  = (count_q != '0);
  assign out_instr  = instr_mem_q[head_q];
  assign out_pc     = pc_mem_q[head_q];
  assign fifo_count = count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a cycle model queues expected PCs as fetches are issued and
// checks them against the FIFO head, plus directed checks on the listed scenarios.
module tb_instr_fetch_ctrl;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [31:0] imem_instr;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic [1:0]  fifo_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] m_fpc;
  logic [15:0] m_q[$];
  logic [15:0] exp_wrap [4];

  instr_fetch_ctrl #(
    .ADDRESS_WIDTH(16),
    .DATA_WIDTH   (32),
    .RESET_PC     (0),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [15:0] a);
    return 32'h1000_0000 + {18'b0, a[15:2]};
  endfunction

  assign imem_instr = rom(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare against the model, advance model.
  task automatic cycle(input logic rdy, input logic hlt, input logic rv, input logic [15:0] rpc);
    logic pop;
    int   sz;
    @(negedge clk);
    rst_n = 1'b1; out_ready = rdy; halt = hlt; redirect_valid = rv; redirect_pc = rpc;
    #1;
    sz = m_q.size();
    check("out_valid", 32'(out_valid), 32'(sz != 0));
    check("fifo_count", 32'(fifo_count), 32'(sz));
    check("imem_addr", 32'(imem_addr), 32'(m_fpc));
    if (sz != 0) begin
      check("out_pc", 32'(out_pc), 32'(m_q[0]));
      check("out_instr", out_instr, rom(m_q[0]));
    end
    pop = (sz != 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (rv) begin
      m_q.delete();
      m_fpc = {rpc[15:2], 2'b00};
    end else if (!hlt && (sz < D || pop)) begin
      m_q.push_back(m_fpc);
      m_fpc = m_fpc + 16'd4;
    end
  endtask

  // Reset asserted between edges; released by the next cycle() call.
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    m_q.delete();
    m_fpc = 16'd0;
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_fpc = 16'd0;
    exp_wrap = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
    #1;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_fifo_count", 32'(fifo_count), 32'd0);
    check("init_imem_addr", 32'(imem_addr), 32'd0);
    check("init_out_pc", 32'(out_pc), 32'd0);
    check("init_out_instr", out_instr, 32'd0);

    // Stream from reset, one instruction per cycle
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("t1_valid_before_edge1", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_pc", 32'(out_pc), 32'(4 * i));
      check("t1_instr", out_instr, 32'h1000_0000 + 32'(i));
    end

    // Back-pressure saturates the FIFO, then stream resumes without gap or duplicate
    async_reset();
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("t2_count_sat", 32'(fifo_count), 32'd2);
    check("t2_fpc_stop", 32'(imem_addr), 32'h8);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      check("t2_pc", 32'(out_pc), 32'(4 * i));
    end

    // Redirect with a full FIFO and a concurrent pop
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("t3_full", 32'(fifo_count), 32'd2);
    cycle(1'b1, 1'b0, 1'b1, 16'h0043);
    check("t3_head_xfer", 32'(out_valid), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("t3_flush_valid", 32'(out_valid), 32'd0);
    check("t3_flush_count", 32'(fifo_count), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("t3_redir_pc", 32'(out_pc), 32'h40);
    check("t3_redir_instr", out_instr, 32'h1000_0010);

    // Halt drains buffered entries and freezes the PC
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 16'h0);
    check("t4_drained", 32'(out_valid), 32'd0);
    check("t4_frozen_pc", 32'(imem_addr), 32'h48);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("t4_resume_pc", 32'(out_pc), 32'h48);

    // PC wraps at the top of the address space
    cycle(1'b1, 1'b0, 1'b1, 16'hFFF8);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("t5_bubble", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'h0);
      check("t5_wrap_pc", 32'(out_pc), 32'(exp_wrap[i]));
    end

    // Asynchronous reset mid-stream with a full FIFO
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check("t6_full", 32'(fifo_count), 32'd2);
    async_reset();
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("t6_valid_after_rel", 32'(out_valid), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("t6_first_pc", 32'(out_pc), 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0);
    check("t6_second_pc", 32'(out_pc), 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the combinational instruction ROM. It owns the fetch PC and drives the ROM byte address. It captures returned instructions into a small prefetch FIFO and presents them to decode over a valid/ready handshake. Decode or branch logic can redirect the PC, and a halt input freezes fetching without losing buffered instructions.

Parameters:
ADDRESS_WIDTH, 16, width of byte address / PC (matches ROM address width)
DATA_WIDTH, 32, instruction width
RESET_PC, 0, PC loaded on reset; must be a multiple of 4
FIFO_DEPTH, 2, prefetch entries; power of two, legal range 2..8

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  ADDRESS_WIDTH  byte address to ROM; always equals fetch PC (combinational from register)
imem_instr  in  DATA_WIDTH  ROM data for imem_addr, valid same cycle
halt  in  1  1 = suppress new fetches; buffered entries still drain
redirect_valid  in  1  1 = discard pipeline, restart fetch at redirect_pc
redirect_pc  in  ADDRESS_WIDTH  new fetch byte address
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head this cycle
out_instr  out  DATA_WIDTH  instruction at FIFO head
out_pc  out  ADDRESS_WIDTH  byte address of out_instr
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries

Behaviour:
- Reset (async assert, any time, including mid-stream):
  - fpc = RESET_PC; FIFO empty.
  - out_valid = 0, fifo_count = 0; out_instr/out_pc = 0.
  - imem_addr = RESET_PC.
- pop = out_valid && out_ready. A transfer completes on any edge where pop=1, including redirect cycles.
- push = !redirect_valid && !halt && (fifo_count < FIFO_DEPTH || pop).
  - On push, the entry {fpc, imem_instr} is written at the tail and fpc <= fpc + 4.
  - Increment is modulo 2^ADDRESS_WIDTH: the PC wraps, so (2^AW - 4) -> 0.
- Full FIFO with simultaneous pop: push is allowed, count is unchanged, no bubble.
- Empty FIFO: out_valid=0; out_instr/out_pc hold the last value (don't-care to checker).
- Redirect (redirect_valid=1 at an edge):
  - Takes priority over halt and push.
  - All FIFO entries are flushed, count becomes 0.
  - fpc <= {redirect_pc[AW-1:2], 2'b00}; low two bits are ignored.
  - A pop in the same cycle is still a completed transfer for the consumer.
  - out_valid=0 in the following cycle; the first redirected instruction is valid one cycle later (redirect-to-out_valid = 2 edges).
- Halt: fpc frozen, no pushes; pops continue.
  - Deasserting halt resumes fetch at the frozen fpc on the next edge.
- Latency:
  - After reset release, the first edge pushes RESET_PC, so out_valid=1 after edge 1.
  - Steady state with out_ready=1 gives one instruction per cycle.
- FIFO is a circular buffer with head/tail pointers of width $clog2(FIFO_DEPTH); pointers wrap naturally.
- No combinational path from out_ready to imem_addr.
- The same-cycle pop→push path is permitted; imem_addr depends only on fpc.

Test Plan:
1. Reset, ROM word i = 0x1000_0000+i, out_ready=1 -> out_valid rises after edge 1; out_pc sequence 0,4,8,12 with out_instr 0x10000000..0x10000003, one per cycle.
2. out_ready=0 for 5 cycles, then 1 -> fifo_count saturates at FIFO_DEPTH (2) and fpc stops at 8; after release the stream continues 0,4,8,12 with no gap or duplicate.
3. Redirect to 0x0043 while the FIFO holds 2 entries and out_ready=1 -> the head transfer completes; next cycle out_valid=0 and count=0; the following cycle out_pc=0x0040 with instr word 16.
4. halt=1 for 3 cycles with out_ready=1 -> buffered entries drain, out_valid=0, imem_addr constant; on halt=0 fetch resumes at the frozen PC.
5. Redirect to 0xFFF8 -> out_pc sequence 0xFFF8, 0xFFFC, 0x0000, 0x0004 (wrap).
6. Assert rst_n low mid-stream between edges with the FIFO full -> out_valid=0 and imem_addr=RESET_PC immediately; after release, resume from RESET_PC.
